// File: rtl/video_timing_gen_if.sv
// Pixel write port, status and 15 kHz video outputs of video_timing_gen.
// master = memory-fetch engine / sink side, slave = the timing generator.
interface video_timing_gen_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic          wr_en;
    logic [11:0]   wr_data;
    logic          fifo_full;
    logic [LW-1:0] fifo_level;
    logic          line_req;
    logic          frame_start;
    logic          err_clr;
    logic          underflow;
    logic          overflow;
    logic          hs_out;
    logic          vs_out;
    logic          de;
    logic [3:0]    r_out;
    logic [3:0]    g_out;
    logic [3:0]    b_out;

    modport master (
        output wr_en, wr_data, err_clr,
        input  fifo_full, fifo_level, line_req, frame_start, underflow, overflow,
               hs_out, vs_out, de, r_out, g_out, b_out
    );

    modport slave (
        input  wr_en, wr_data, err_clr,
        output fifo_full, fifo_level, line_req, frame_start, underflow, overflow,
               hs_out, vs_out, de, r_out, g_out, b_out
    );
endinterface

// File: rtl/video_timing_gen.sv
// 15 kHz video timing source: H/V counters on ce_pix, pixel FIFO fed by the fetch engine,
// registered sync/DE/RGB with one pixel of latency, line request and sticky FIFO error flags.
module video_timing_gen #(
    parameter int H_TOTAL      = 512,
    parameter int H_ACTIVE     = 320,
    parameter int H_SYNC_START = 400,
    parameter int H_SYNC_WIDTH = 48,
    parameter int V_TOTAL      = 313,
    parameter int V_ACTIVE     = 200,
    parameter int V_SYNC_START = 250,
    parameter int V_SYNC_WIDTH = 3,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ce_pix,
    video_timing_gen_if.slave vif
);
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic [31:0]   h_ext;
    logic [31:0]   v_ext;

    logic          visible;
    logic          h_last;
    logic          v_last;
    logic          hs_win;
    logic          vs_win;
    logic          next_vis;

    logic [11:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic          empty;
    logic          full;
    logic          pop_req;
    logic          do_pop;
    logic          do_push;
    logic          uf_set;
    logic          of_set;

    logic          hs_q;
    logic          vs_q;
    logic          de_q;
    logic [11:0]   rgb_q;
    logic          line_req_q;
    logic          frame_start_q;
    logic          underflow_q;
    logic          overflow_q;

    assign h_ext = 32'(hcnt);
    assign v_ext = 32'(vcnt);

    // Sync windows may run past the end of the line/frame; the second term covers the wrapped part.
    always_comb begin
        visible  = (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE);
        h_last   = (h_ext == H_TOTAL - 1);
        v_last   = (v_ext == V_TOTAL - 1);
        hs_win   = ((h_ext >= H_SYNC_START) && (h_ext < H_SYNC_START + H_SYNC_WIDTH)) ||
                   (h_ext + H_TOTAL < H_SYNC_START + H_SYNC_WIDTH);
        vs_win   = ((v_ext >= V_SYNC_START) && (v_ext < V_SYNC_START + V_SYNC_WIDTH)) ||
                   (v_ext + V_TOTAL < V_SYNC_START + V_SYNC_WIDTH);
        next_vis = v_last ? 1'b1 : (v_ext + 32'd1 < V_ACTIVE);
    end

    // No bypass: a pop only sees entries present before this cycle, so a full FIFO still
    // accepts a push whenever a pop drains it in the same cycle.
    always_comb begin
        empty   = (level == '0);
        full    = (level == LW'(FIFO_DEPTH));
        pop_req = ce_pix && visible;
        do_pop  = pop_req && !empty;
        do_push = vif.wr_en && (!full || do_pop);
        uf_set  = pop_req && empty;
        of_set  = vif.wr_en && full && !do_pop;
    end

    always_ff @(posedge clk_sys) begin
        if (do_push) begin
            mem[wr_ptr] <= vif.wr_data;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            hcnt          <= '0;
            vcnt          <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            de_q          <= 1'b0;
            rgb_q         <= '0;
            line_req_q    <= 1'b0;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            line_req_q    <= 1'b0;
            frame_start_q <= 1'b0;

            if (ce_pix) begin
                hcnt <= h_last ? '0 : hcnt + 1'b1;
                if (h_last) begin
                    vcnt <= v_last ? '0 : vcnt + 1'b1;
                end
                de_q  <= visible;
                rgb_q <= do_pop ? mem[rd_ptr] : '0;
                hs_q  <= !hs_win;
                if (h_ext == H_SYNC_START) begin
                    vs_q <= !vs_win;
                end
                line_req_q    <= (h_ext == H_ACTIVE) && next_vis;
                frame_start_q <= (hcnt == '0) && (vcnt == '0);
            end

            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level + LW'(do_push) - LW'(do_pop);

            if (uf_set) begin
                underflow_q <= 1'b1;
            end else if (vif.err_clr) begin
                underflow_q <= 1'b0;
            end
            if (of_set) begin
                overflow_q <= 1'b1;
            end else if (vif.err_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign vif.fifo_full   = full;
    assign vif.fifo_level  = level;
    assign vif.line_req    = line_req_q;
    assign vif.frame_start = frame_start_q;
    assign vif.underflow   = underflow_q;
    assign vif.overflow    = overflow_q;
    assign vif.hs_out      = hs_q;
    assign vif.vs_out      = vs_q;
    assign vif.de          = de_q;
    assign vif.r_out       = rgb_q[11:8];
    assign vif.g_out       = rgb_q[7:4];
    assign vif.b_out       = rgb_q[3:0];
endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized bench for video_timing_gen with scaled-down timing; a tick-count/queue reference
// model predicts every output on every clk_sys cycle.
module tb_video_timing_gen;
    localparam int HT    = 64;
    localparam int HA    = 40;
    localparam int HSS   = 60;
    localparam int HSW   = 8;
    localparam int VT    = 20;
    localparam int VA    = 12;
    localparam int VSS   = 15;
    localparam int VSW   = 2;
    localparam int DEPTH = 16;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    logic ce_pix  = 1'b0;

    video_timing_gen_if #(.FIFO_DEPTH(DEPTH)) vif ();

    video_timing_gen #(
        .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_WIDTH(HSW),
        .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_WIDTH(VSW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_sys(clk_sys),
        .reset  (reset),
        .ce_pix (ce_pix),
        .vif    (vif)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    // Reference model: position derived from the number of pixel ticks since reset.
    int          ticks;
    logic [11:0] q[$];
    logic        m_hs, m_vs, m_de, m_lr, m_fs, m_uf, m_of;
    logic [11:0] m_rgb;
    int          m_req_line;

    int          pending;
    logic [11:0] next_word;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        ticks = 0;
        q.delete();
        m_hs = 1'b1; m_vs = 1'b1; m_de = 1'b0; m_rgb = '0;
        m_lr = 1'b0; m_fs = 1'b0; m_uf = 1'b0; m_of = 1'b0;
        m_req_line = 0;
    endtask

    task automatic model_step();
        int h, v;
        logic uf_set, of_set;
        logic [11:0] pix;
        h = ticks % HT;
        v = (ticks / HT) % VT;
        uf_set = 1'b0; of_set = 1'b0; pix = '0;
        if (ce_pix && h < HA && v < VA) begin
            if (q.size() > 0) pix = q.pop_front();
            else uf_set = 1'b1;
        end
        if (vif.wr_en) begin
            if (q.size() < DEPTH) q.push_back(vif.wr_data);
            else of_set = 1'b1;
        end
        m_uf = uf_set | (m_uf & ~vif.err_clr);
        m_of = of_set | (m_of & ~vif.err_clr);
        m_lr = 1'b0;
        m_fs = 1'b0;
        if (ce_pix) begin
            m_de  = (h < HA) && (v < VA);
            m_rgb = pix;
            m_hs  = !(((h - HSS + HT) % HT) < HSW);
            if (h == HSS) m_vs = !(((v - VSS + VT) % VT) < VSW);
            m_req_line = (v + 1) % VT;
            m_lr  = (h == HA) && (m_req_line < VA);
            m_fs  = (h == 0) && (v == 0);
            ticks++;
        end
    endtask

    task automatic check_outputs();
        check_eq("hs_out", vif.hs_out, m_hs);
        check_eq("vs_out", vif.vs_out, m_vs);
        check_eq("de", vif.de, m_de);
        check_eq("rgb", {vif.r_out, vif.g_out, vif.b_out}, m_rgb);
        check_eq("line_req", vif.line_req, m_lr);
        check_eq("frame_start", vif.frame_start, m_fs);
        check_eq("underflow", vif.underflow, m_uf);
        check_eq("overflow", vif.overflow, m_of);
        check_eq("fifo_level", 32'(vif.fifo_level), q.size());
        check_eq("fifo_full", vif.fifo_full, q.size() == DEPTH);
    endtask

    task automatic tick_clk();
        @(posedge clk_sys);
        if (!reset) model_step();
        @(negedge clk_sys);
        check_outputs();
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_hs"}, vif.hs_out, 1);
        check_eq({tag, "_vs"}, vif.vs_out, 1);
        check_eq({tag, "_de"}, vif.de, 0);
        check_eq({tag, "_level"}, 32'(vif.fifo_level), 0);
        check_eq({tag, "_rgb"}, {vif.r_out, vif.g_out, vif.b_out}, 0);
        check_eq({tag, "_flags"}, {vif.underflow, vif.overflow, vif.line_req, vif.frame_start}, 0);
    endtask

    initial begin
        int target;
        vif.wr_en = 1'b0; vif.wr_data = '0; vif.err_clr = 1'b0;
        model_reset();
        pending = 0; next_word = '0;

        repeat (3) @(negedge clk_sys);
        check_reset_state("por");
        check_outputs();
        reset = 1'b0;

        // Phase 1: streaming three frames; line 5 of frame 1 is never fed.
        target = 3 * HT * VT + 7 * HT + 30;
        for (int cyc = 0; cyc < target * 8 && ticks < target; cyc++) begin
            ce_pix      = ($urandom_range(0, 3) == 0);
            vif.err_clr = ($urandom_range(0, 49) == 0);
            if (pending > 0 && q.size() < DEPTH && $urandom_range(0, 3) != 0) begin
                vif.wr_en = 1'b1; vif.wr_data = next_word;
                next_word++; pending--;
            end else begin
                vif.wr_en = 1'b0;
            end
            tick_clk();
            if (m_lr && !(m_req_line == 5 && ticks / (HT * VT) == 1)) begin
                pending = HA; next_word = '0;
            end
        end
        check_eq("reached_reset_point", ticks, target);

        // Mid-frame reset at hcnt=30, vcnt=7.
        ce_pix = 1'b0; vif.wr_en = 1'b0; vif.err_clr = 1'b0;
        #1 reset = 1'b1;
        model_reset();
        #1 check_reset_state("midrst");
        check_outputs();
        tick_clk();
        reset = 1'b0;

        // Phase 2: FIFO boundaries with counters frozen at hcnt=0, vcnt=0.
        for (int i = 0; i < 17; i++) begin
            vif.wr_en = 1'b1; vif.wr_data = 12'hA00 + 12'(i);
            tick_clk();
        end
        vif.wr_en = 1'b0;
        check_eq("ovf_level", 32'(vif.fifo_level), 16);
        check_eq("ovf_full", vif.fifo_full, 1);
        check_eq("ovf_flag", vif.overflow, 1);
        vif.err_clr = 1'b1;
        tick_clk();
        vif.err_clr = 1'b0;
        check_eq("ovf_cleared", vif.overflow, 0);

        ce_pix = 1'b1; vif.wr_en = 1'b1; vif.wr_data = 12'hB00;
        tick_clk();
        vif.wr_en = 1'b0;
        check_eq("full_pushpop_level", 32'(vif.fifo_level), 16);
        check_eq("full_pushpop_ovf", vif.overflow, 0);
        check_eq("first_frame_start", vif.frame_start, 1);
        check_eq("first_pixel", {vif.r_out, vif.g_out, vif.b_out}, 12'hA00);
        repeat (16) tick_clk();
        check_eq("drain_level", 32'(vif.fifo_level), 0);
        check_eq("last_pixel_not_17th", {vif.r_out, vif.g_out, vif.b_out}, 12'hB00);

        vif.wr_en = 1'b1; vif.wr_data = 12'hC00;
        tick_clk();
        vif.wr_en = 1'b0; ce_pix = 1'b0;
        check_eq("empty_pushpop_uf", vif.underflow, 1);
        check_eq("empty_pushpop_level", 32'(vif.fifo_level), 1);
        check_eq("empty_pushpop_de", vif.de, 1);
        check_eq("empty_pushpop_rgb", {vif.r_out, vif.g_out, vif.b_out}, 0);

        // Phase 3: unconstrained random traffic including overflow and clears.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            ce_pix      = ($urandom_range(0, 1) == 0);
            vif.err_clr = ($urandom_range(0, 19) == 0);
            vif.wr_en   = ($urandom_range(0, 4) < 2);
            vif.wr_data = 12'($urandom);
            tick_clk();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
